cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
Run/step/breakpoint controller for the single-cycle RISC-V core on the board. It replaces the free-running divided clock. The core, instruction memory and data memory all run on clk. They advance only on cycles where cpu_en is high. The block debounces two push-buttons, generates the enable pulses in free-run or single-step mode, halts on a PC breakpoint, and counts retired instructions for the HEX display.

Parameters:
DIV_BITS, 22, free-run tick period is 2^DIV_BITS clk cycles (about 11.9 Hz at 50 MHz)
DB_CYCLES, 500000, consecutive stable cycles a synchronized key must hold before its debounced level changes (10 ms at 50 MHz)

Ports:
clk  input  1  system clock (50 MHz)
reset_n  input  1  asynchronous active-low reset
key_step_n  input  1  raw step button, active-low, asynchronous to clk
key_run_n  input  1  raw run/halt toggle button, active-low, asynchronous to clk
pc  input  32  current core PC
brk_addr  input  32  breakpoint address
brk_en  input  1  breakpoint enable
cpu_en  output  1  registered; one-cycle enable pulse, exactly one instruction retires per pulse
state  output  2  registered FSM state: 00 HALT, 01 RUN, 10 STEP, 11 BREAK
halted  output  1  high when state is HALT or BREAK
instr_count  output  16  number of cpu_en pulses issued since reset

Behaviour:
- Reset (reset_n low, asynchronous assert): state=HALT, cpu_en=0, halted=1, instr_count=0, divider=0, debounced levels=1 (released), skip_brk=0.
- Key conditioning, per key:
  - 2-flop synchronizer feeds a stability counter.
  - The debounced level takes the synchronized value after DB_CYCLES consecutive cycles of disagreement; any agreement clears the counter.
  - A press is a one-cycle pulse on the debounced 1->0 edge. Release generates nothing. Holding a key generates one press.
- FSM, evaluated every clk (press pulses sampled in cycle N act at edge N+1):
  - HALT:
    - run press -> RUN, divider cleared to 0.
    - else step press -> STEP.
  - STEP:
    - cpu_en=1 for this single cycle, increment instr_count, then -> HALT unconditionally.
    - Presses during STEP are dropped.
  - RUN:
    - divider increments every cycle, wrapping at 2^DIV_BITS-1.
    - On wrap (tick), if brk_en and pc==brk_addr and skip_brk=0: -> BREAK, no pulse.
    - Otherwise on tick: cpu_en=1 next cycle, instr_count++, skip_brk cleared.
    - run press -> HALT, divider cleared; run press beats a coincident tick (no pulse).
    - step press ignored.
  - BREAK:
    - Behaves as HALT.
    - run press -> RUN with skip_brk=1, so the first tick ignores the breakpoint match and the instruction at brk_addr executes.
    - step press -> STEP; STEP never checks the breakpoint.
- Simultaneous run and step press: run wins, step discarded.
- cpu_en is never high on two consecutive cycles.
- In RUN, the first pulse comes exactly 2^DIV_BITS cycles after entry.
- instr_count wraps 0xFFFF -> 0x0000.
- halted is decoded from the state register, with no extra latency.
- brk_en=0 disables matching entirely. pc is sampled only on tick cycles.
- Reset asserted mid-RUN or mid-STEP: immediate return to reset values. No pending pulse survives.

Test Plan:
(Bench uses DIV_BITS=3, DB_CYCLES=4.)
1. Reset, then hold both keys released for 50 cycles -> state=00, cpu_en never 1, instr_count=0, halted=1.
2. Step key low for 10 cycles, then high; repeat 3 times -> exactly 3 single-cycle cpu_en pulses, instr_count=3, state returns to 00 after each. A 3-cycle glitch on key_step_n -> no pulse.
3. Run press, wait 80 cycles -> cpu_en pulses every 8 cycles (10 pulses), instr_count=10. Second run press -> state=00, no further pulses.
4. brk_en=1, brk_addr=0x10, bench pc steps +4 per cpu_en from 0 -> 4 pulses, then state=11 with pc=0x10. Run press -> next tick pulses (pc 0x10 executes), RUN continues.
5. Run and step pressed on the same cycle from HALT -> state=01, no STEP pulse.
6. Reset_n asserted 2 cycles into RUN with instr_count=5 -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// Bundle of the debug-controller signals shared between the board-side
// logic (buttons, core PC, breakpoint setup) and the step controller.
//
// Enable protocol: cpu_en is a registered, single-cycle strobe. Every cycle
// it is high, the core, instruction memory and data memory advance by
// exactly one instruction. There is no back-pressure; the consumer must
// accept each strobe. Two strobes are never adjacent.
interface cpu_step_ctrl_if;
  logic        key_step_n;
  logic        key_run_n;
  logic [31:0] pc;
  logic [31:0] brk_addr;
  logic        brk_en;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  // Board side: drives buttons, PC and breakpoint; observes the controller.
  modport master (
    output key_step_n, key_run_n, pc, brk_addr, brk_en,
    input  cpu_en, state, halted, instr_count
  );

  // Controller side.
  modport slave (
    input  key_step_n, key_run_n, pc, brk_addr, brk_en,
    output cpu_en, state, halted, instr_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Run / single-step / breakpoint controller for the single-cycle core.
// Debounces the step and run buttons, produces one-cycle cpu_en strobes
// (free-running at clk / 2^DIV_BITS, or one per step press), halts when
// the PC hits the breakpoint, and counts retired instructions.
module cpu_step_ctrl #(
  parameter int DIV_BITS  = 22,
  parameter int DB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset_n,
  cpu_step_ctrl_if.slave  bus
);

  localparam int                DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam int                STEP_K  = 0;
  localparam int                RUN_K   = 1;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  // Key conditioning: index 0 = step key, index 1 = run key.
  logic [1:0]      key_raw;
  logic [1:0]      key_meta;
  logic [1:0]      key_sync;
  logic [1:0]      key_db;
  logic [1:0]      key_press;
  logic [DB_W-1:0] db_cnt [2];

  // Sequencer state.
  state_t               st;
  logic [DIV_BITS-1:0]  div;
  logic                 cpu_en_r;
  logic [15:0]          count;
  logic                 skip_brk;

  logic tick;
  logic brk_hit;
  logic run_press;
  logic step_press;

  assign key_raw    = {bus.key_run_n, bus.key_step_n};
  assign run_press  = key_press[RUN_K];
  assign step_press = key_press[STEP_K];

  // Divider wraps on the cycle it holds all ones; that cycle is the tick.
  assign tick    = &div;
  // A match is ignored once right after resuming from a breakpoint.
  assign brk_hit = bus.brk_en && (bus.pc == bus.brk_addr) && !skip_brk;

  // Synchronize, debounce and edge-detect both keys. The debounced level
  // follows the synchronized key only after DB_CYCLES straight cycles of
  // disagreement; a press pulse fires on the debounced falling edge only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta  <= 2'b11;
      key_sync  <= 2'b11;
      key_db    <= 2'b11;
      key_press <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      key_meta  <= key_raw;
      key_sync  <= key_meta;
      key_press <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        if (key_sync[k] == key_db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_cnt[k]    <= '0;
          key_db[k]    <= key_sync[k];
          key_press[k] <= ~key_sync[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Main sequencer: state, divider, enable strobe and retire counter.
  // cpu_en and instr_count change on the same edge so the count always
  // equals the number of strobes issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st       <= ST_HALT;
      div      <= '0;
      cpu_en_r <= 1'b0;
      count    <= '0;
      skip_brk <= 1'b0;
    end else begin
      cpu_en_r <= 1'b0;
      case (st)
        ST_HALT, ST_BREAK: begin
          if (run_press) begin
            st       <= ST_RUN;
            div      <= '0;
            skip_brk <= (st == ST_BREAK);
          end else if (step_press) begin
            st       <= ST_STEP;
            cpu_en_r <= 1'b1;
            count    <= count + 16'd1;
          end
        end
        ST_STEP: begin
          st <= ST_HALT;
        end
        ST_RUN: begin
          if (run_press) begin
            st  <= ST_HALT;
            div <= '0;
          end else begin
            div <= div + 1'b1;
            if (tick) begin
              if (brk_hit) begin
                st <= ST_BREAK;
              end else begin
                cpu_en_r <= 1'b1;
                count    <= count + 16'd1;
                skip_brk <= 1'b0;
              end
            end
          end
        end
        default: begin
          st <= ST_HALT;
        end
      endcase
    end
  end

  assign bus.cpu_en      = cpu_en_r;
  assign bus.state       = st;
  assign bus.halted      = (st == ST_HALT) || (st == ST_BREAK);
  assign bus.instr_count = count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl with a short divider and debounce window.
module tb_cpu_step_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cpu_step_ctrl_if bus ();

  cpu_step_ctrl #(
    .DIV_BITS  (3),
    .DB_CYCLES (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Core model: PC advances by 4 on each strobe while tracking is enabled.
  logic [31:0] core_pc = 32'h0;
  bit          pc_track = 1'b0;
  assign bus.pc = core_pc;

  int   pulse_cnt = 0;
  int   dbl_cnt   = 0;
  logic prev_en   = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  typedef struct {
    int         step_lo;
    int         run_lo;
    int         total;
    int         exp_pulses;
    logic [1:0] exp_state;
    logic       exp_halted;
    int         exp_count;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.cpu_en === 1'b1) begin
      pulse_cnt++;
      if (prev_en) dbl_cnt++;
      if (pc_track) begin
        obs_q.push_back(core_pc);
        core_pc = core_pc + 32'd4;
      end
    end
    prev_en = (bus.cpu_en === 1'b1);
  end

  // Hold the selected keys low for their given cycle counts inside a window
  // of 'total' cycles and report how many strobes occurred in the window.
  task automatic run_window(input int step_lo, input int run_lo, input int total,
                            output int pulses);
    int start;
    start = pulse_cnt;
    if (step_lo > 0) bus.key_step_n = 1'b0;
    if (run_lo > 0)  bus.key_run_n  = 1'b0;
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (i == step_lo) bus.key_step_n = 1'b1;
      if (i == run_lo)  bus.key_run_n  = 1'b1;
    end
    #1;
    pulses = pulse_cnt - start;
  endtask

  initial begin
    int p;
    int lim;

    //            step run tot pulses state  hlt count
    vecs[0] = '{0,  0,  50, 0,  2'b00, 1'b1, 0};   // idle
    vecs[1] = '{10, 0,  25, 1,  2'b00, 1'b1, 1};   // step
    vecs[2] = '{10, 0,  25, 1,  2'b00, 1'b1, 2};   // step
    vecs[3] = '{10, 0,  25, 1,  2'b00, 1'b1, 3};   // step
    vecs[4] = '{3,  0,  20, 0,  2'b00, 1'b1, 3};   // 3-cycle glitch
    vecs[5] = '{0,  10, 88, 10, 2'b01, 1'b0, 13};  // free run
    vecs[6] = '{0,  10, 30, 0,  2'b00, 1'b1, 13};  // stop, coincides with tick
    vecs[7] = '{5,  5,  14, 0,  2'b01, 1'b0, 13};  // run+step together
    vecs[8] = '{0,  10, 30, 1,  2'b00, 1'b1, 14};  // stop after one more tick

    bus.key_step_n = 1'b1;
    bus.key_run_n  = 1'b1;
    bus.brk_addr   = 32'h0;
    bus.brk_en     = 1'b0;

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state",  32'(bus.state), 32'h0);
    check("rst_cpu_en", 32'(bus.cpu_en), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h1);
    check("rst_count",  32'(bus.instr_count), 32'h0);
    reset_n = 1'b1;
    #1;

    // Table-driven windows; brk_en=0 with pc==brk_addr checks disable.
    for (int v = 0; v < 9; v++) begin
      run_window(vecs[v].step_lo, vecs[v].run_lo, vecs[v].total, p);
      check($sformatf("v%0d_pulses", v), 32'(p), 32'(vecs[v].exp_pulses));
      check($sformatf("v%0d_state", v),  32'(bus.state), 32'(vecs[v].exp_state));
      check($sformatf("v%0d_halted", v), 32'(bus.halted), 32'(vecs[v].exp_halted));
      check($sformatf("v%0d_count", v),  32'(bus.instr_count), 32'(vecs[v].exp_count));
    end

    // Breakpoint at 0x10: four strobes, break, resume executes 0x10.
    bus.brk_addr = 32'h10;
    bus.brk_en   = 1'b1;
    pc_track     = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};

    run_window(0, 10, 60, p);
    check("brk_pulses", 32'(p), 32'd4);
    check("brk_state",  32'(bus.state), 32'h3);
    check("brk_halted", 32'(bus.halted), 32'h1);
    check("brk_count",  32'(bus.instr_count), 32'd18);

    run_window(0, 10, 30, p);
    check("resume_pulses", 32'(p), 32'd2);
    check("resume_state",  32'(bus.state), 32'h1);
    check("resume_count",  32'(bus.instr_count), 32'd20);

    run_window(0, 10, 30, p);
    check("brk_stop_pulses", 32'(p), 32'd1);
    check("brk_stop_state",  32'(bus.state), 32'h0);
    check("brk_stop_count",  32'(bus.instr_count), 32'd21);

    pc_track   = 1'b0;
    bus.brk_en = 1'b0;
    check("pc_trace_len", 32'(obs_q.size()), 32'(exp_q.size()));
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++) begin
      check($sformatf("pc_trace%0d", i), obs_q[i], exp_q[i]);
    end

    // Asynchronous reset while a strobe is on the wire.
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bus.key_run_n = 1'b0;
    repeat (10) @(negedge clk);
    bus.key_run_n = 1'b1;
    for (int i = 0; i < 300 && bus.instr_count != 16'd5; i++) @(negedge clk);
    check("reach_count5", 32'(bus.instr_count), 32'd5);
    check("pre_rst_cpu_en", 32'(bus.cpu_en), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_state",  32'(bus.state), 32'h0);
    check("async_cpu_en", 32'(bus.cpu_en), 32'h0);
    check("async_halted", 32'(bus.halted), 32'h1);
    check("async_count",  32'(bus.instr_count), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    run_window(0, 0, 30, p);
    check("post_rst_pulses", 32'(p), 32'd0);
    check("post_rst_state",  32'(bus.state), 32'h0);

    check("no_back_to_back", 32'(dbl_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
